rf_writeback_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback sources:
//  ALU (single-cycle) and LSU (load/long-latency). Sits between execute/memory

---
 rtl/rf_writeback_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
// Shares the single register-file write port between the ALU and LSU
// writeback sources. The ALU has fixed priority. An LSU starvation guard
// gives the LSU priority for one grant after MAX_WAIT consecutive blocked
// cycles. The write port is registered, so a transfer in cycle N appears
// on rf_* in cycle N+1.
// Optional feature: define WB_SCOREBOARD_EN to add a pending-LSU-write
// busy vector with source-register lookup ports.
module rf_writeback_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_waddr,
   input  logic [DATA_W-1:0] alu_wdata,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_waddr,
   input  logic [DATA_W-1:0] lsu_wdata,
`ifdef WB_SCOREBOARD_EN
   input  logic              lsu_issue_valid,
   input  logic [ADDR_W-1:0] lsu_issue_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   output logic              busy_rs1,
   output logic              busy_rs2,
`endif
   output logic              rf_reg_wr,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_STARVE = 1'b1;

   logic [0:0]        state_r;
   logic [0:0]        state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_nxt_s;
   logic              alu_grant_s;
   logic              lsu_grant_s;
   logic              alu_xfer_s;
   logic              lsu_xfer_s;

   // Grant decision from the request lines and the current priority state.
   always_comb begin
      alu_grant_s = 1'b0;
      lsu_grant_s = 1'b0;
      if (reset) begin
         alu_grant_s = 1'b0;
         lsu_grant_s = 1'b0;
      end else begin
         case (state_r)
            ST_NORMAL: begin
               alu_grant_s = alu_valid;
               lsu_grant_s = lsu_valid && !alu_valid;
            end
            ST_STARVE: begin
               lsu_grant_s = lsu_valid;
               alu_grant_s = alu_valid && !lsu_valid;
            end
            default: begin
               alu_grant_s = 1'b0;
               lsu_grant_s = 1'b0;
            end
         endcase
      end
   end

   assign alu_ready  = alu_grant_s;
   assign lsu_ready  = lsu_grant_s;
   assign alu_xfer_s = alu_valid && alu_grant_s;
   assign lsu_xfer_s = lsu_valid && lsu_grant_s;

   // The wait counter tracks consecutive blocked LSU cycles and saturates at MAX_WAIT.
   always_comb begin
      wait_cnt_nxt_s = wait_cnt_r;
      if (lsu_xfer_s || !lsu_valid) begin
         wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end else if (wait_cnt_r != WAIT_MAX) begin
         wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_nxt_s = wait_cnt_r;
      end
   end

   // Enter STARVE once the LSU has waited MAX_WAIT cycles; leave it after one LSU turn.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_NORMAL: begin
            if (wait_cnt_nxt_s == WAIT_MAX) begin
               state_nxt_s = ST_STARVE;
            end else begin
               state_nxt_s = ST_NORMAL;
            end
         end
         ST_STARVE: begin
            if (lsu_xfer_s || !lsu_valid) begin
               state_nxt_s = ST_NORMAL;
            end else begin
               state_nxt_s = ST_STARVE;
            end
         end
         default: state_nxt_s = ST_NORMAL;
      endcase
   end

   // Priority state and wait counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_NORMAL;
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Registered write port. Writes to x0 are accepted but never enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_reg_wr <= 1'b0;
         rf_waddr  <= {ADDR_W{1'b0}};
         rf_wdata  <= {DATA_W{1'b0}};
      end else if (alu_xfer_s) begin
         rf_reg_wr <= (alu_waddr != {ADDR_W{1'b0}});
         rf_waddr  <= alu_waddr;
         rf_wdata  <= alu_wdata;
      end else if (lsu_xfer_s) begin
         rf_reg_wr <= (lsu_waddr != {ADDR_W{1'b0}});
         rf_waddr  <= lsu_waddr;
         rf_wdata  <= lsu_wdata;
      end else begin
         rf_reg_wr <= 1'b0;
      end
   end

`ifdef WB_SCOREBOARD_EN
   localparam int NREG = 1 << ADDR_W;

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] busy_nxt_s;

   // A clear on LSU writeback is applied first, so an issue to the same register wins.
   always_comb begin
      busy_nxt_s = busy_r;
      if (lsu_xfer_s) begin
         busy_nxt_s[lsu_waddr] = 1'b0;
      end else begin
         busy_nxt_s = busy_r;
      end
      if (lsu_issue_valid && (lsu_issue_rd != {ADDR_W{1'b0}})) begin
         busy_nxt_s[lsu_issue_rd] = 1'b1;
      end else begin
         busy_nxt_s[0] = 1'b0;
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Pending LSU destination register.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_r <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy_rs1 = busy_r[chk_rs1];
   assign busy_rs2 = busy_r[chk_rs2];
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: a vector table for single-cycle
// behaviour plus hand-written starvation, reset and scoreboard sequences.
module tb_rf_writeback_arbiter;

   logic        clock;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_waddr;
   logic [31:0] alu_wdata;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_waddr;
   logic [31:0] lsu_wdata;
   logic        rf_reg_wr;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_SCOREBOARD_EN
   logic        lsu_issue_valid;
   logic [4:0]  lsu_issue_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        busy_rs1;
   logic        busy_rs2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
      .clock(clock),
      .reset(reset),
      .alu_valid(alu_valid),
      .alu_ready(alu_ready),
      .alu_waddr(alu_waddr),
      .alu_wdata(alu_wdata),
      .lsu_valid(lsu_valid),
      .lsu_ready(lsu_ready),
      .lsu_waddr(lsu_waddr),
      .lsu_wdata(lsu_wdata),
`ifdef WB_SCOREBOARD_EN
      .lsu_issue_valid(lsu_issue_valid),
      .lsu_issue_rd(lsu_issue_rd),
      .chk_rs1(chk_rs1),
      .chk_rs2(chk_rs2),
      .busy_rs1(busy_rs1),
      .busy_rs2(busy_rs2),
`endif
      .rf_reg_wr(rf_reg_wr),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        e_ar;
      logic        e_lr;
      logic        e_wr;
      logic        chk_ad;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      alu_valid = av;
      alu_waddr = aa;
      alu_wdata = ad;
      lsu_valid = lv;
      lsu_waddr = la;
      lsu_wdata = ld;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      clock = 1'b0;
      reset = 1'b1;
      drive(1'b1, 5'd4, 32'h11, 1'b1, 5'd6, 32'h22);
`ifdef WB_SCOREBOARD_EN
      lsu_issue_valid = 1'b0;
      lsu_issue_rd    = 5'd0;
      chk_rs1         = 5'd0;
      chk_rs2         = 5'd0;
`endif

      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hA5A5A5A5};
      vecs[4] = '{1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1};
      vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h2, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h2};
      vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

      // Reset with requests pending: nothing accepted, outputs zero.
      tick();
      tick();
      check("reset_alu_ready", 32'(alu_ready), 32'd0);
      check("reset_lsu_ready", 32'(lsu_ready), 32'd0);
      check("reset_rf_reg_wr", 32'(rf_reg_wr), 32'd0);
      check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
      check("reset_rf_wdata", rf_wdata, 32'd0);
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      check("post_reset_wr", 32'(rf_reg_wr), 32'd0);

      // Single-cycle vector table.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
         #1;
         check($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
         check($sformatf("vec%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
         tick();
         check($sformatf("vec%0d_rf_reg_wr", i), 32'(rf_reg_wr), 32'(vecs[i].e_wr));
         if (vecs[i].chk_ad) begin
            check($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_data);
         end
      end

      // Both sources valid continuously: four ALU grants, then one LSU grant.
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 5'd10, 32'h100 + 32'(k), 1'b1, 5'd11, 32'h200 + 32'(k));
         #1;
         check($sformatf("starve%0d_alu_ready", k), 32'(alu_ready), 32'((k % 5) != 4));
         check($sformatf("starve%0d_lsu_ready", k), 32'(lsu_ready), 32'((k % 5) == 4));
         tick();
         check($sformatf("starve%0d_wr", k), 32'(rf_reg_wr), 32'd1);
         check($sformatf("starve%0d_waddr", k), 32'(rf_waddr), ((k % 5) == 4) ? 32'd11 : 32'd10);
         check($sformatf("starve%0d_wdata", k), rf_wdata,
               ((k % 5) == 4) ? (32'h200 + 32'(k)) : (32'h100 + 32'(k)));
      end

      // Build up LSU wait, then reset the cycle after an ALU grant.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5'd12, 32'hCAFE, 1'b1, 5'd13, 32'hBEEF);
         tick();
      end
      check("pre_reset_wr", 32'(rf_reg_wr), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_reset_alu_ready", 32'(alu_ready), 32'd0);
      check("mid_reset_lsu_ready", 32'(lsu_ready), 32'd0);
      tick();
      check("mid_reset_wr", 32'(rf_reg_wr), 32'd0);
      check("mid_reset_waddr", 32'(rf_waddr), 32'd0);
      check("mid_reset_wdata", rf_wdata, 32'd0);
      tick();
      reset = 1'b0;
      check("reset_hold_wr", 32'(rf_reg_wr), 32'd0);
      // Wait count must restart from zero: four ALU grants before the LSU.
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("after_reset%0d_alu_ready", k), 32'(alu_ready), 32'(k != 4));
         check($sformatf("after_reset%0d_lsu_ready", k), 32'(lsu_ready), 32'(k == 4));
         tick();
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();

`ifdef WB_SCOREBOARD_EN
      // Issue rd=9 and check busy until the LSU writes x9 back.
      lsu_issue_valid = 1'b1;
      lsu_issue_rd    = 5'd9;
      chk_rs1         = 5'd9;
      chk_rs2         = 5'd8;
      tick();
      lsu_issue_valid = 1'b0;
      check("sb_busy_set_rs1", 32'(busy_rs1), 32'd1);
      check("sb_other_rs2", 32'(busy_rs2), 32'd0);
      drive(1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 32'h0);
      tick();
      check("sb_alu_no_clear", 32'(busy_rs1), 32'd1);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h6);
      lsu_issue_valid = 1'b1;
      lsu_issue_rd    = 5'd9;
      tick();
      check("sb_set_wins", 32'(busy_rs1), 32'd1);
      lsu_issue_valid = 1'b0;
      tick();
      check("sb_cleared", 32'(busy_rs1), 32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      lsu_issue_valid = 1'b1;
      lsu_issue_rd    = 5'd0;
      chk_rs1         = 5'd0;
      tick();
      lsu_issue_valid = 1'b0;
      check("sb_x0_never_busy", 32'(busy_rs1), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
